uart_parity_checker_stream: RTL and testbench

- Serial, parametrised parity checker for the UART RX path.
- Accepts a frame one bit per strobe, LSB first: DATA_W data bits, then one parity bit.
- Accumulates parity on the fly and checks the parity bit against a run-time mode (even/odd/mark/space).
- Presents the assembled data word and an error flag through a valid/ready result interface. Sits between the RX bit sampler and the RX FIFO.

---
 rtl/uart_parity_pkg.sv | 30 +++
 rtl/uart_parity_err_counter.sv | 22 ++
 rtl/uart_parity_checker_stream.sv | 125 ++++++++++++
 tb/tb_uart_parity_checker_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_parity_pkg.sv
// Shared mode codes, FSM encoding and parity helper for the UART RX parity checker.
package uart_parity_pkg;

    typedef logic [1:0] par_mode_t;

    localparam par_mode_t PAR_EVEN  = 2'b00;
    localparam par_mode_t PAR_ODD   = 2'b01;
    localparam par_mode_t PAR_MARK  = 2'b10;
    localparam par_mode_t PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10,
        RESULT = 2'b11
    } state_e;

    // Parity bit the transmitter should have sent, given the running XOR of the data bits.
    function automatic logic expected_parity(input par_mode_t m, input logic acc);
        logic e;
        unique case (m)
            PAR_EVEN:  e = acc;
            PAR_ODD:   e = ~acc;
            PAR_MARK:  e = 1'b1;
            PAR_SPACE: e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/uart_parity_err_counter.sv
// Saturating event counter with synchronous clear; clear wins over a same-cycle increment.
module uart_parity_err_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_parity_checker_stream.sv
// Serial UART RX parity checker: assembles DATA_W bits LSB first, checks the parity bit,
// returns the word over valid/ready. Error counter present only with PARITY_ERR_CNT_EN.
module uart_parity_checker_stream
    import uart_parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 abort,
    input  logic                 res_ready,
    output logic                 res_valid,
    output logic [DATA_W-1:0]    data_out,
    output logic                 parity_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 cnt_clr
);

    localparam int unsigned IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            state;
    logic [DATA_W-1:0] sr;
    logic              acc;
    logic [IDX_W-1:0]  idx;
    par_mode_t         mode_q;

    // Frame FSM with registered result interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            acc        <= 1'b0;
            idx        <= '0;
            mode_q     <= PAR_EVEN;
            res_valid  <= 1'b0;
            parity_err <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= DATA;
                        busy   <= 1'b1;
                        sr     <= '0;
                        acc    <= 1'b0;
                        idx    <= '0;
                        mode_q <= mode;
                    end
                end
                DATA: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        sr  <= {bit_in, sr[DATA_W-1:1]};
                        acc <= acc ^ bit_in;
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_valid) begin
                        parity_err <= (bit_in != expected_parity(mode_q, acc));
                        data_out   <= sr;
                        res_valid  <= 1'b1;
                        state      <= RESULT;
                    end
                end
                RESULT: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        // start on the handshake chains straight into the next frame
                        if (start) begin
                            state  <= DATA;
                            sr     <= '0;
                            acc    <= 1'b0;
                            idx    <= '0;
                            mode_q <= mode;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic cnt_inc_c;
    assign cnt_inc_c = (state == RESULT) && res_ready && !abort && parity_err;

    uart_parity_err_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc_c),
        .clr   (cnt_clr),
        .count (err_count)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_uart_parity_checker_stream.sv
// Scoreboard bench for uart_parity_checker_stream; counter expectations follow PARITY_ERR_CNT_EN.
module tb_uart_parity_checker_stream;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ERR_CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic                 bit_valid = 1'b0;
    logic                 bit_in = 1'b0;
    logic                 abort = 1'b0;
    logic                 res_ready = 1'b0;
    logic                 res_valid;
    logic [DATA_W-1:0]    data_out;
    logic                 parity_err;
    logic                 busy;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 cnt_clr = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              perr;
    } exp_t;

    exp_t                 q[$];
    logic [ERR_CNT_W-1:0] cnt_exp = '0;
    logic [1:0]           cur_mode = 2'b00;
    int                   n_vec = 0;
    int                   n_err = 0;

    uart_parity_checker_stream #(
        .DATA_W    (DATA_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .abort      (abort),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .data_out   (data_out),
        .parity_err (parity_err),
        .busy       (busy),
        .err_count  (err_count),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] m);
        start    = 1'b1;
        mode     = m;
        cur_mode = m;
        tick();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: busy=%b required 1", busy);
        end
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = d[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_parity(input logic [DATA_W-1:0] d, input logic p);
        logic ebit;
        case (cur_mode)
            2'b00:   ebit = ^d;
            2'b01:   ebit = ~^d;
            2'b10:   ebit = 1'b1;
            default: ebit = 1'b0;
        endcase
        q.push_back('{data: d, perr: (p != ebit)});
        bit_valid = 1'b1;
        bit_in    = p;
        tick();
        bit_valid = 1'b0;
        n_vec++;
        if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL result_latency: res_valid=%b required 1", res_valid);
        end
    endtask

    task automatic handshake(input logic clr, input logic next_start, input logic [1:0] next_mode);
        exp_t e;
        e = '0;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: queue size=0 required >0");
        end else begin
            e = q.pop_front();
        end
        n_vec++;
        if (data_out !== e.data || parity_err !== e.perr) begin
            n_err++;
            $display("FAIL result: data_out=%h parity_err=%b required %h %b",
                     data_out, parity_err, e.data, e.perr);
        end
        res_ready = 1'b1;
        cnt_clr   = clr;
        start     = next_start;
        mode      = next_mode;
        if (next_start) cur_mode = next_mode;
        tick();
        res_ready = 1'b0;
        cnt_clr   = 1'b0;
        start     = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        if (clr) cnt_exp = '0;
        else if (e.perr && cnt_exp != '1) cnt_exp = cnt_exp + ERR_CNT_W'(1);
`endif
        n_vec++;
        if (res_valid !== 1'b0 || busy !== next_start) begin
            n_err++;
            $display("FAIL post_handshake: res_valid=%b busy=%b required 0 %b",
                     res_valid, busy, next_start);
        end
        n_vec++;
        if (err_count !== cnt_exp) begin
            n_err++;
            $display("FAIL err_count: got %0d required %0d", err_count, cnt_exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (res_valid !== 1'b0 || parity_err !== 1'b0 || busy !== 1'b0 ||
            data_out !== '0 || err_count !== '0) begin
            n_err++;
            $display("FAIL reset: res_valid=%b parity_err=%b busy=%b data_out=%h err_count=%0d required all 0",
                     res_valid, parity_err, busy, data_out, err_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_even();
        start_frame(2'b00);
        send_bits(8'hA5, 8);
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_valid: res_valid=%b required 0", res_valid);
        end
        send_parity(8'hA5, 1'b0);
        handshake(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_mismatch();
        start_frame(2'b01);
        send_bits(8'hA5, 8);
        send_parity(8'hA5, 1'b0);
        handshake(1'b0, 1'b0, 2'b00);
        start_frame(2'b10);
        send_bits(8'hA5, 8);
        send_parity(8'hA5, 1'b0);
        handshake(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_backpressure();
        start_frame(2'b00);
        send_bits(8'h5B, 8);
        send_parity(8'h5B, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            start     = 1'b1;
            mode      = 2'b11;
            tick();
            n_vec++;
            if (res_valid !== 1'b1 || busy !== 1'b1 ||
                data_out !== q[0].data || parity_err !== q[0].perr) begin
                n_err++;
                $display("FAIL backpressure_hold: res_valid=%b busy=%b data_out=%h parity_err=%b required 1 1 %h %b",
                         res_valid, busy, data_out, parity_err, q[0].data, q[0].perr);
            end
        end
        bit_valid = 1'b0;
        start     = 1'b0;
        handshake(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_back_to_back();
        start_frame(2'b01);
        send_bits(8'h81, 8);
        send_parity(8'h81, 1'b1);
        handshake(1'b0, 1'b1, 2'b00);
        send_bits(8'h3C, 8);
        send_parity(8'h3C, 1'b0);
        handshake(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_abort();
        start_frame(2'b00);
        send_bits(8'hFF, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || err_count !== cnt_exp) begin
            n_err++;
            $display("FAIL abort_data: busy=%b res_valid=%b err_count=%0d required 0 0 %0d",
                     busy, res_valid, err_count, cnt_exp);
        end
        start_frame(2'b11);
        send_bits(8'h12, 8);
        send_parity(8'h12, 1'b1);
        res_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        void'(q.pop_front());
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || err_count !== cnt_exp) begin
            n_err++;
            $display("FAIL abort_result: busy=%b res_valid=%b err_count=%0d required 0 0 %0d",
                     busy, res_valid, err_count, cnt_exp);
        end
        start_frame(2'b00);
        send_bits(8'h07, 8);
        send_parity(8'h07, 1'b1);
        handshake(1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            start_frame(2'b10);
            send_bits(DATA_W'(8'h10 + k), 8);
            send_parity(DATA_W'(8'h10 + k), 1'b0);
            handshake(1'b0, 1'b0, 2'b00);
        end
        start_frame(2'b11);
        send_bits(8'hC3, 8);
        send_parity(8'hC3, 1'b1);
        handshake(1'b1, 1'b0, 2'b00);
    endtask

    task automatic test_mid_reset();
        start_frame(2'b00);
        send_bits(8'hAA, 3);
        rst_n = 1'b0;
        #1;
        cnt_exp = '0;
        q.delete();
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || data_out !== '0 || err_count !== '0) begin
            n_err++;
            $display("FAIL mid_reset: busy=%b res_valid=%b data_out=%h err_count=%0d required 0 0 00 0",
                     busy, res_valid, data_out, err_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(2'b01);
        send_bits(8'h01, 8);
        send_parity(8'h01, 1'b0);
        handshake(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_even();
        test_mismatch();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
